// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StResp  = 2'b10
  } arb_state_e;

  localparam int unsigned PortA = 0;
  localparam int unsigned PortB = 1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker; ptr = 1 favours port B, lock forces B on contention.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ptr,
  input  logic       lock,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_a && req_b) begin
      if (lock || ptr) begin
        gnt[PortB] = 1'b1;
      end else begin
        gnt[PortA] = 1'b1;
      end
    end else if (req_a) begin
      gnt[PortA] = 1'b1;
    end else if (req_b) begin
      gnt[PortB] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto one synchronous single-port memory (IDLE -> ISSUE -> RESP).
// Define MEM_ARB_LOCK_EN to add the B_Lock input that lets port B hold off port A.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 A_Req,
  input  logic                 A_Wr,
  input  logic [AddrWidth-1:0] A_Addr,
  input  logic [DataWidth-1:0] A_DIn,
  output logic                 A_Ack,
  output logic                 A_Gnt,
  input  logic                 B_Req,
  input  logic                 B_Wr,
  input  logic [AddrWidth-1:0] B_Addr,
  input  logic [DataWidth-1:0] B_DIn,
  output logic                 B_Ack,
  output logic                 B_Gnt,
`ifdef MEM_ARB_LOCK_EN
  input  logic                 B_Lock,
`endif
  output logic [DataWidth-1:0] DOut,
  output logic [AddrWidth-1:0] MEM_Addr,
  output logic [DataWidth-1:0] MEM_DIn,
  output logic                 MEM_WE,
  input  logic [DataWidth-1:0] MEM_DOut
);

  arb_state_e           state_q;
  logic                 ptr_q;
  logic                 win_q;
  logic                 wr_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] din_q;
  logic                 a_gnt_q, b_gnt_q;
  logic                 a_ack_q, b_ack_q;
  logic                 lock;
  logic [1:0]           pick;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q;
  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  rr_arbiter2 u_rr_arbiter2 (
    .req_a (A_Req),
    .req_b (B_Req),
    .ptr   (ptr_q),
    .lock  (lock),
    .gnt   (pick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick != 2'b00) begin
            win_q   <= pick[PortB];
            wr_q    <= pick[PortB] ? B_Wr : A_Wr;
            addr_q  <= pick[PortB] ? B_Addr : A_Addr;
            din_q   <= pick[PortB] ? B_DIn : A_DIn;
            a_gnt_q <= pick[PortA];
            b_gnt_q <= pick[PortB];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          // Write strobe lives only in ISSUE; the memory commits on this edge.
          wr_q    <= 1'b0;
          a_ack_q <= ~win_q;
          b_ack_q <= win_q;
          state_q <= StResp;
        end
        StResp: begin
          a_gnt_q <= 1'b0;
          b_gnt_q <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
          if (win_q && B_Lock) begin
            lock_q <= 1'b1;
          end else begin
            if (win_q) lock_q <= 1'b0;
            ptr_q <= ~win_q;
          end
`else
          ptr_q <= ~win_q;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign A_Ack    = a_ack_q;
  assign B_Ack    = b_ack_q;
  assign A_Gnt    = a_gnt_q;
  assign B_Gnt    = b_gnt_q;
  assign MEM_Addr = addr_q;
  assign MEM_DIn  = din_q;
  assign MEM_WE   = wr_q & ~Reset;
  // The memory output register already aligns read data with the RESP cycle.
  assign DOut     = (a_ack_q | b_ack_q) ? MEM_DOut : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter driving a registered-read memory model.
module tb_mem_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       A_Req = 1'b0, A_Wr = 1'b0;
  logic [7:0] A_Addr = '0, A_DIn = '0;
  logic       B_Req = 1'b0, B_Wr = 1'b0;
  logic [7:0] B_Addr = '0, B_DIn = '0;
  logic       A_Ack, A_Gnt, B_Ack, B_Gnt, MEM_WE;
  logic [7:0] DOut, MEM_Addr, MEM_DIn;
  logic [7:0] MEM_DOut = '0;
`ifdef MEM_ARB_LOCK_EN
  logic       B_Lock = 1'b0;
`endif

  always #5 Clk = ~Clk;

  mem_arbiter #(.DataWidth(8), .AddrWidth(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .A_Req    (A_Req),
    .A_Wr     (A_Wr),
    .A_Addr   (A_Addr),
    .A_DIn    (A_DIn),
    .A_Ack    (A_Ack),
    .A_Gnt    (A_Gnt),
    .B_Req    (B_Req),
    .B_Wr     (B_Wr),
    .B_Addr   (B_Addr),
    .B_DIn    (B_DIn),
    .B_Ack    (B_Ack),
    .B_Gnt    (B_Gnt),
`ifdef MEM_ARB_LOCK_EN
    .B_Lock   (B_Lock),
`endif
    .DOut     (DOut),
    .MEM_Addr (MEM_Addr),
    .MEM_DIn  (MEM_DIn),
    .MEM_WE   (MEM_WE),
    .MEM_DOut (MEM_DOut)
  );

  logic [7:0] mem [0:255];

  always @(posedge Clk) begin
    if (MEM_WE) mem[MEM_Addr] <= MEM_DIn;
    MEM_DOut <= mem[MEM_Addr];
  end

  typedef struct packed {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic port, input logic req, input logic wr,
                       input logic [7:0] addr, input logic [7:0] din);
    if (port) begin
      B_Req = req; B_Wr = wr; B_Addr = addr; B_DIn = din;
    end else begin
      A_Req = req; A_Wr = wr; A_Addr = addr; A_DIn = din;
    end
  endtask

  // Single transaction: checks latency, write strobe width and strobe address/data.
  task automatic access(input logic port, input logic wr, input logic [7:0] addr,
                        input logic [7:0] din, input logic [7:0] rdata);
    int   cnt = 0;
    int   we_cnt = 0;
    logic got = 1'b0;
    exp_q.push_back('{port: port, rd: !wr, data: rdata});
    drive(port, 1'b1, wr, addr, din);
    while (!got && cnt < 8) begin
      step();
      cnt++;
      if (MEM_WE) begin
        we_cnt++;
        check("we_addr", {24'h0, MEM_Addr}, {24'h0, addr});
        check("we_data", {24'h0, MEM_DIn}, {24'h0, din});
      end
      got = port ? B_Ack : A_Ack;
    end
    check("latency", cnt, 2);
    check("we_cycles", we_cnt, {31'h0, wr});
    drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Monitor: every Ack pops one expected response.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (!Reset && (A_Ack || B_Ack)) begin
      check("ack_onehot", {31'h0, A_Ack & B_Ack}, 0);
      check("gnt_onehot", {31'h0, A_Gnt & B_Gnt}, 0);
      check("gnt_with_ack", {31'h0, B_Ack ? B_Gnt : A_Gnt}, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", {31'h0, B_Ack}, {31'h0, e.port});
        if (e.rd) check("dout", {24'h0, DOut}, {24'h0, e.data});
      end
    end
  end

  task automatic run_both(input int cycles, input int lock_drop, output int n,
                          output int t[8], output logic p[8]);
    n = 0;
    for (int c = 1; c <= cycles; c++) begin
      step();
      if ((A_Ack || B_Ack) && n < 8) begin
        t[n] = c;
        p[n] = B_Ack;
        n++;
      end
`ifdef MEM_ARB_LOCK_EN
      if (c == lock_drop) B_Lock = 1'b0;
`else
      if (c == lock_drop) n = n;
`endif
    end
    A_Req = 1'b0;
    B_Req = 1'b0;
  endtask

  int   n;
  int   t[8];
  logic p[8];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hC3);
    mem[8'h10] = 8'h5A;
    mem[8'h40] = 8'h44;

    // Reset state
    repeat (2) step();
    check("rst_acks", {30'h0, A_Ack, B_Ack}, 0);
    check("rst_gnts", {30'h0, A_Gnt, B_Gnt}, 0);
    check("rst_we", {31'h0, MEM_WE}, 0);
    check("rst_bus", {8'h0, MEM_Addr, MEM_DIn, DOut}, 0);
    Reset = 1'b0;
    step();

    // A read, then B write followed by A read-back
    access(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
    step();
    access(1'b1, 1'b1, 8'h20, 8'h33, 8'h00);
    step();
    access(1'b0, 1'b0, 8'h20, 8'h00, 8'h33);
    step();

    // A drops Req during ISSUE; Ack still pulses, then everything goes quiet
    exp_q.push_back('{port: 1'b0, rd: 1'b1, data: 8'h33});
    drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    step();
    check("drop_gnt_issue", {31'h0, A_Gnt}, 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("drop_ack_resp", {31'h0, A_Ack}, 1);
    step();
    step();
    check("quiet_idle", {27'h0, A_Gnt, B_Gnt, A_Ack, B_Ack, MEM_WE}, 0);

    // Reset during B's write ISSUE must not commit the write
    drive(1'b1, 1'b1, 1'b1, 8'h40, 8'hFF);
    step();
    check("b_gnt_issue", {31'h0, B_Gnt}, 1);
    check("we_before_rst", {31'h0, MEM_WE}, 1);
    Reset = 1'b1;
    #1;
    check("we_under_rst", {31'h0, MEM_WE}, 0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("rst_abort_ack", {30'h0, A_Ack, B_Ack}, 0);
    check("rst_abort_gnt", {30'h0, A_Gnt, B_Gnt}, 0);
    Reset = 1'b0;
    step();
    check("no_late_ack", {31'h0, B_Ack}, 0);
    check("mem40_kept", {24'h0, mem[8'h40]}, 32'h44);
    access(1'b0, 1'b0, 8'h40, 8'h00, 8'h44);
    step();

    // Both ports requesting continuously from reset: A, B, A, B every 3 cycles
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{port: 1'b0, rd: 1'b1, data: 8'h5A});
      exp_q.push_back('{port: 1'b1, rd: 1'b1, data: 8'h33});
    end
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    run_both(11, 0, n, t, p);
    check("rr_count", n, 4);
    for (int i = 0; i < 4 && i < n; i++) begin
      check("rr_port", {31'h0, p[i]}, i % 2);
      check("rr_time", t[i], 2 + 3 * i);
    end
    step();

`ifdef MEM_ARB_LOCK_EN
    // Lock: after B's first RESP with lock, B keeps winning until lock drops at a B RESP
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    B_Lock = 1'b1;
    exp_q.push_back('{port: 1'b0, rd: 1'b1, data: 8'h5A});
    for (int i = 0; i < 4; i++) exp_q.push_back('{port: 1'b1, rd: 1'b1, data: 8'h33});
    exp_q.push_back('{port: 1'b0, rd: 1'b1, data: 8'h5A});
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    run_both(17, 12, n, t, p);
    check("lock_count", n, 6);
    for (int i = 0; i < 6 && i < n; i++) begin
      check("lock_port", {31'h0, p[i]}, (i == 0 || i == 5) ? 0 : 1);
      check("lock_time", t[i], 2 + 3 * i);
    end
    step();
`endif

    repeat (4) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous Memory between two requesters: port A (CPU fetch/data path) and port B (external loader/debug master).
- Sits between the requesters and the Memory instance; replaces the CPU's direct address/data/write-enable hookup.
- Serialises accesses through a 3-state FSM with round-robin arbitration and a one-cycle Ack pulse that returns read data.

Parameters:
- DataWidth, 8, width of data buses.
- AddrWidth, 8, width of memory address.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- A_Req  in  1  port A request; held until A_Ack.
- A_Wr  in  1  port A: 1 = write, 0 = read.
- A_Addr  in  AddrWidth  port A address.
- A_DIn  in  DataWidth  port A write data.
- A_Ack  out  1  one-cycle completion pulse for port A.
- A_Gnt  out  1  high while port A owns the memory.
- B_Req, B_Wr, B_Addr, B_DIn, B_Ack, B_Gnt  same as port A, for port B.
- DOut  out  DataWidth  read data; valid only while an Ack is high.
- MEM_Addr  out  AddrWidth  to Memory Address.
- MEM_DIn  out  DataWidth  to Memory DIn.
- MEM_WE  out  1  to Memory Write_EN.
- MEM_DOut  in  DataWidth  from Memory DOut; registered, 1-cycle read latency.

Behaviour:
- Reset values: state IDLE; A_Ack, B_Ack, A_Gnt, B_Gnt, MEM_WE = 0; MEM_Addr, MEM_DIn, DOut = 0; round-robin pointer favours A.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port not served last; the pointer picks A after reset.
  - On grant: latch Wr/Addr/DIn into internal registers, set the grant bit (the port's Gnt output), go to ISSUE.
- ISSUE:
  - Drive MEM_Addr/MEM_DIn from the latched values.
  - MEM_WE = latched Wr; it is high for exactly this one cycle.
  - Go to RESP.
- RESP:
  - Register MEM_DOut into DOut.
  - Pulse the winner's Ack for one cycle; Ack is also high for writes, with DOut unspecified.
  - Toggle the pointer to the other port, go to IDLE.
- Latency: Req sampled high in IDLE at cycle N -> Ack high in cycle N+2.
- Throughput: one access per 3 cycles.
- Gnt timing: high from the cycle after grant through the RESP cycle.
- Handshake:
  - Requester keeps Req and its fields stable until Ack.
  - Requester deasserts Req at the edge where it samples Ack.
  - Req still high in the following IDLE cycle is treated as a new transaction.
- Field changes after grant are ignored, because the fields are latched at grant.
- Back-to-back, both ports requesting continuously: grants strictly alternate A, B, A, B.
- Req dropped before Ack: the in-flight transaction still completes and Ack still pulses.
- Reset in any state: next state IDLE, in-flight transaction aborted, no Ack.
- MEM_WE is forced to 0 in any cycle where Reset is high, so a write in ISSUE coincident with Reset is not committed.
- Only one of A_Ack/B_Ack and one of A_Gnt/B_Gnt may be high in any cycle.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Enabled:
  - Adds input B_Lock (1 bit).
  - If B_Lock is high when B's transaction reaches RESP, the pointer is not toggled.
  - In IDLE, B wins any A/B contention while the lock holds.
  - If B_Req is low in IDLE, A may still be granted.
  - Intended for bulk program loading with the CPU held off.
  - The lock clears when B_Lock is low at a B RESP, or on Reset.
- Disabled: no B_Lock port; pure alternating round-robin.

Decomposition:
- Shared package: FSM state encodings (IDLE=2'b00, ISSUE=2'b01, RESP=2'b10) and port index constants (PORT_A=0, PORT_B=1).
- Natural sub-module: rr_arbiter2.
  - Combinational 2-way round-robin picker.
  - Inputs: two reqs, pointer, lock. Outputs: one-hot grant.
  - mem_arbiter owns the FSM, latches and pointer register.

Test Plan:
- Reset, A read 0x10 (memory[0x10]=0x5A) -> A_Ack at cycle N+2, DOut=0x5A, B_Ack stays 0.
- B write 0x33 to 0x20, then A read 0x20 -> MEM_WE high exactly one cycle in B's ISSUE, A read returns 0x33.
- A and B both request continuously from reset -> grant order A,B,A,B; Acks 3 cycles apart; never both high.
- Reset asserted during B's ISSUE cycle (write 0xFF to 0x40) -> memory[0x40] unchanged, no B_Ack, state IDLE next cycle.
- A drops Req in ISSUE -> A_Ack still pulses in RESP; next IDLE with no request stays idle, all outputs quiet.
- With MEM_ARB_LOCK_EN and B_Lock=1, both requesting -> four consecutive B grants, A granted only after B_Lock=0 at a B RESP.
